supercomputer_mk3: RTL
======================

# supercomputer_mk3

Parametrised successor to the mk2 accumulator machine: a single-accumulator command processor with a `DATA_W`-bit accumulator `A`, an `ADDR_W`-bit memory pointer `P` and a `2**ADDR_W`-word data memory. Commands are queued in an input FIFO and executed at up to one per cycle. The block adds load-from-memory, pointer increment, logic ops, and carry/zero flags. It sits between the host command interface and the debug output pins (`out`, `mem_adr`, `jam`).

## Interface
- `DATA_W`, 8: width of `A`, `arg`, `out` and memory words.
- `ADDR_W`, 4: pointer width; memory depth is `2**ADDR_W`.
- `FIFO_DEPTH`, 4: command FIFO entries; must be a power of two and at least 2.
- `clk` in 1: single clock; all state changes on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `handshake` in 1: command offer; sampled at rising edge.
- `cmd` in 8: opcode.
- `arg` in `DATA_W`: operand.
- `ready` out 1: FIFO can accept a command.
- `mem_adr` out `ADDR_W`: current `P`.
- `out` out `DATA_W`: current `A`.
- `carry` out 1: carry/borrow from last ADD/SUB.
- `zero` out 1: `A == 0` after last A-writing op.
- `jam` out 1: CPU jammed; only reset clears it.

## Operation
- Accept: `handshake && ready` at a rising edge pushes `{cmd,arg}`. `handshake` while `!ready` is dropped silently; the host must re-offer.
- FSM states:
  - RUN: pop the FIFO head if non-empty and execute it; if empty, idle.
  - MEMRD: second cycle of LDM; `A <= mem[P]`, then return to RUN.
  - JAM: terminal until `rstn` low.
- Opcodes:
  - 00 CLR: `A <= 0`.
  - 01 NOT: `A <= ~A`.
  - 02 LDA: `A <= arg`.
  - 03 LDP: `P <= arg[ADDR_W-1:0]`.
  - 04 ADD: `{carry,A} <= A+arg`.
  - 05 SUB: `{carry,A} <= A-arg`; carry is the borrow.
  - 06 STA: `mem[P] <= A`.
  - 07 NOP.
  - 08 LDM: two cycles, via MEMRD.
  - 09 INCP: `P <= P+1`, wrapping `2**ADDR_W-1` to 0.
  - 0A AND, 0B OR, 0C XOR: `A <= A op arg`.
  - FF JAM.
  - Any other opcode executes as NOP.
- Flags:
  - `zero` is updated by every A-writing op: CLR, NOT, LDA, ADD, SUB, LDM, AND, OR, XOR.
  - `carry` is updated only by ADD/SUB; all other ops hold it.
- Arithmetic is modulo `2**DATA_W`; `arg` is unsigned.
- JAM: on execution, `jam <= 1`, FIFO is flushed, `ready` is forced to 0, and no further command executes or is accepted. `A`, `P`, flags and memory hold their values.

## Timing
- Reset values: `A=0`, `P=0`, `carry=0`, `zero=1`, `jam=0`, FIFO empty, state RUN, so `ready=1`. Memory is not reset.
- Latency: a command accepted at edge N into an empty FIFO executes at edge N+1; `out`/`mem_adr`/flags are valid after N+1. LDM results appear after N+2.
- Throughput: one command per cycle. LDM stalls the head for one extra cycle.
- `ready = !full && state != JAM`. It does not account for a same-cycle pop (conservative); a push while full never occurs.
- Simultaneous push and pop on a non-full FIFO: both take effect and the count is unchanged.
- STA followed immediately by LDM at the same `P` must return the stored value (write-before-read ordering).
- `rstn` asserted mid-LDM or mid-queue: all state returns to reset values immediately. Queued commands are lost.

## Structure
- Package `supercomputer_pkg`:
  - opcode constants (`OP_CLR` ... `OP_JAM`);
  - FSM state enum (`ST_RUN`, `ST_MEMRD`, `ST_JAM`).
- Sub-module `sc_cmd_fifo`:
  - parameters `WIDTH`, `DEPTH`;
  - push/pop/flush ports; full/empty outputs;
  - asynchronous active-low reset.
- The top level holds the FSM, datapath and memory array.

## Test plan
- Reset, then LDA 88, ADD 02, SUB 8A, NOT back-to-back -> `out` reads 88, 8A, 00 (`zero=1`, `carry=0`), FF, one per cycle.
- LDA FF, ADD 01 -> `out=00`, `carry=1`, `zero=1`. Then SUB 01 -> `out=FF`, `carry=1` (borrow).
- LDP 0F, INCP -> `mem_adr=0`. LDP 07, LDA FF, STA, CLR, LDM -> `out=FF` two cycles after LDM is popped.
- With the executor stalled by LDMs, offer 6 commands with `FIFO_DEPTH=4` -> `ready` drops at 4 entries, excess offers are dropped, and the accepted 4 execute in order.
- JAM, then LDA 00 offered -> `jam=1`, `ready=0`, `out` unchanged. Pulse `rstn`, then LDA 44, NOP -> `jam=0`, `out=44`, `mem_adr=0`.
- Assert `rstn` during LDM with 3 commands queued -> `out=0`, `ready=1`, and no queued command executes after release.

Source files
------------

// File: rtl/supercomputer_mk3_pkg.sv
// supercomputer_pkg
// Shared definitions for the supercomputer_mk3 command processor:
//   - 8-bit opcode constants executed from the command FIFO
//   - executor FSM state encoding
package supercomputer_pkg;

  localparam logic [7:0] OP_CLR  = 8'h00;
  localparam logic [7:0] OP_NOT  = 8'h01;
  localparam logic [7:0] OP_LDA  = 8'h02;
  localparam logic [7:0] OP_LDP  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h04;
  localparam logic [7:0] OP_SUB  = 8'h05;
  localparam logic [7:0] OP_STA  = 8'h06;
  localparam logic [7:0] OP_NOP  = 8'h07;
  localparam logic [7:0] OP_LDM  = 8'h08;
  localparam logic [7:0] OP_INCP = 8'h09;
  localparam logic [7:0] OP_AND  = 8'h0A;
  localparam logic [7:0] OP_OR   = 8'h0B;
  localparam logic [7:0] OP_XOR  = 8'h0C;
  localparam logic [7:0] OP_JAM  = 8'hFF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MEMRD = 2'd1,
    ST_JAM   = 2'd2
  } state_t;

endpackage

// File: rtl/supercomputer_mk3_if.sv
// supercomputer_mk3_if
// Host command channel of the supercomputer_mk3.
//   handshake : command offer from the host
//   cmd       : 8-bit opcode
//   arg       : DATA_W-bit operand
//   ready     : processor can accept a command this cycle
// master = host side, slave = processor side.
interface supercomputer_mk3_if #(
  parameter int DATA_W = 8
);
  logic              handshake;
  logic [7:0]        cmd;
  logic [DATA_W-1:0] arg;
  logic              ready;

  modport master (output handshake, output cmd, output arg, input ready);
  modport slave  (input handshake, input cmd, input arg, output ready);
endinterface

// File: rtl/supercomputer_mk3_cmd_fifo.sv
// sc_cmd_fifo
// Small synchronous FIFO holding queued {cmd,arg} entries.
//   clk, rstn : clock, asynchronous active-low reset (pointers/count only)
//   push, din : write an entry (ignored when full)
//   pop       : discard the head entry (ignored when empty)
//   flush     : empty the FIFO; wins over a same-cycle push/pop
//   dout      : current head entry (combinational read so the executor
//               can decode and retire it in the same cycle)
//   full, empty
// DEPTH must be a power of two so the pointers wrap naturally.
module sc_cmd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign dout    = store[rd_ptr_reg];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/supercomputer_mk3.sv
// supercomputer_mk3
// Single-accumulator command processor. Commands arrive on the host
// interface, queue in sc_cmd_fifo and retire at up to one per cycle.
//   clk, rstn : clock, asynchronous active-low reset
//   host      : command channel (handshake/cmd/arg in, ready out)
//   mem_adr   : pointer P
//   out       : accumulator A
//   carry     : carry/borrow of the last ADD/SUB
//   zero      : A == 0 after the last A-writing op
//   jam       : processor halted by JAM, cleared only by reset
// LDM takes two cycles: the pop cycle launches a registered memory read
// of mem[P], the MEMRD cycle loads it into A.
module supercomputer_mk3
  import supercomputer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rstn,
  supercomputer_mk3_if.slave  host,
  output logic [ADDR_W-1:0]   mem_adr,
  output logic [DATA_W-1:0]   out,
  output logic                carry,
  output logic                zero,
  output logic                jam
);
  localparam int ENTRY_W   = 8 + DATA_W;
  localparam int MEM_DEPTH = 2 ** ADDR_W;

  state_t            state_reg;
  logic [DATA_W-1:0] a_reg;
  logic [ADDR_W-1:0] p_reg;
  logic              carry_reg;
  logic              zero_reg;
  logic              jam_reg;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] mem_rd_reg;
  logic              mem_we;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [7:0]         head_cmd;
  logic [DATA_W-1:0]  head_arg;

  logic [DATA_W-1:0] a_next;
  logic              carry_next;
  logic              a_write;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  assign head_cmd = fifo_head[ENTRY_W-1 -: 8];
  assign head_arg = fifo_head[DATA_W-1:0];

  // ready ignores a same-cycle pop, so a push never lands on a full FIFO.
  assign host.ready = !fifo_full && (state_reg != ST_JAM);
  assign fifo_push  = host.handshake && host.ready;
  assign fifo_pop   = (state_reg == ST_RUN) && !fifo_empty;
  // Executing JAM discards everything queued, including a same-cycle push.
  assign fifo_flush = fifo_pop && (head_cmd == OP_JAM);
  assign mem_we     = fifo_pop && (head_cmd == OP_STA);

  sc_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .din   ({host.cmd, host.arg}),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Accumulator datapath for the head command.
  always_comb begin
    a_next     = a_reg;
    carry_next = carry_reg;
    a_write    = 1'b0;
    sum        = {1'b0, a_reg} + {1'b0, head_arg};
    // MSB of the widened difference is the borrow.
    diff       = {1'b0, a_reg} - {1'b0, head_arg};
    case (head_cmd)
      OP_CLR: begin a_next = '0;                 a_write = 1'b1; end
      OP_NOT: begin a_next = ~a_reg;             a_write = 1'b1; end
      OP_LDA: begin a_next = head_arg;           a_write = 1'b1; end
      OP_ADD: begin {carry_next, a_next} = sum;  a_write = 1'b1; end
      OP_SUB: begin {carry_next, a_next} = diff; a_write = 1'b1; end
      OP_AND: begin a_next = a_reg & head_arg;   a_write = 1'b1; end
      OP_OR:  begin a_next = a_reg | head_arg;   a_write = 1'b1; end
      OP_XOR: begin a_next = a_reg ^ head_arg;   a_write = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_RUN;
      a_reg     <= '0;
      p_reg     <= '0;
      carry_reg <= 1'b0;
      zero_reg  <= 1'b1;
      jam_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (fifo_pop) begin
            a_reg     <= a_next;
            carry_reg <= carry_next;
            if (a_write) zero_reg <= (a_next == '0);
            case (head_cmd)
              OP_LDP:  p_reg <= head_arg[ADDR_W-1:0];
              OP_INCP: p_reg <= p_reg + ADDR_W'(1);
              OP_LDM:  state_reg <= ST_MEMRD;
              OP_JAM: begin
                state_reg <= ST_JAM;
                jam_reg   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_MEMRD: begin
          a_reg     <= mem_rd_reg;
          zero_reg  <= (mem_rd_reg == '0);
          state_reg <= ST_RUN;
        end
        ST_JAM: ;
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  // Data memory with registered read. The read sampled on the LDM pop edge
  // sees any STA written on the previous edge, giving write-before-read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[p_reg] <= a_reg;
    mem_rd_reg <= mem[p_reg];
  end

  assign mem_adr = p_reg;
  assign out     = a_reg;
  assign carry   = carry_reg;
  assign zero    = zero_reg;
  assign jam     = jam_reg;

endmodule
